serial_carry_adder: RTL and testbench

Byte-serial multi-byte adder stage that consumes operand bytes least-significant first and chains the byte-level carry (`{carry, sum} = a + b + carry_in`) across all bytes of a word. It sits directly downstream of the testbench operand generators and upstream of the result checker. It turns the single-cycle 8-bit add-with-carry into a pipelined, handshaked N-byte adder. Valid/ready on both sides; one registered output stage.

---
 rtl/serial_carry_adder.sv | 78 +++++++
 tb/tb_serial_carry_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_carry_adder.sv
// rtl/serial_carry_adder.sv - byte-serial N-slice adder with chained carry and registered output
// Optional word carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_carry_adder #(
  parameter int WIDTH  = 8,
  parameter int NBYTES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  logic [IW-1:0] idx;
  logic          carry_q;
  logic          accept;
  logic          is_last;
  logic          carry_in;
  logic [WIDTH:0] sum_full;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_last  = (idx == LAST_IDX);

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_in = (idx == '0) ? cin : carry_q;
`else
  assign carry_in = carry_q;
`endif

  // Extend to WIDTH+1 before adding so the slice carry is never truncated.
  assign sum_full = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
    end else if (clr) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= sum_full[WIDTH-1:0];
        out_last  <= is_last;
        out_carry <= is_last ? sum_full[WIDTH] : 1'b0;
        if (is_last) begin
          idx     <= '0;
          carry_q <= 1'b0;
        end else begin
          idx     <= idx + 1'b1;
          carry_q <= sum_full[WIDTH];
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_carry_adder.sv
// tb/tb_serial_carry_adder.sv - scoreboard bench for serial_carry_adder
// Honours SERIAL_ADDER_CIN_EN when the design is built with it.
module tb_serial_carry_adder;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_last, out_carry;

  serial_carry_adder #(.WIDTH(W), .NBYTES(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef SERIAL_ADDER_CIN_EN
    .cin(cin),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  logic [9:0] held;
  bit         held_v = 1'b0;
  bit         rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected slice per output handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold_stable", {22'd0, out_valid, out_sum, out_last, out_carry}, {22'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else check("slice", {22'd0, out_sum, out_last, out_carry}, {22'd0, exp_q.pop_front()});
      end
      held_v = out_valid && !out_ready && !clr;
      held   = {out_sum, out_last, out_carry};
    end
  end

  // Reference: the whole word is added at once; slices are cut from the result.
  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic c,
                           input int stall_at, input int abort_at, input int reset_at,
                           input int gap_max);
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef SERIAL_ADDER_CIN_EN
    full = full + 33'(c);
`endif
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_a = a[8*i +: 8];
      in_b = b[8*i +: 8];
      cin = c;
      in_valid = 1'b1;
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_sum", {24'd0, out_sum}, {24'd0, full[8*(i-1) +: 8]});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (i == abort_at) begin
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        return;
      end
      if (i == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {24'd0, out_sum}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_carry", {31'd0, out_carry}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else exp_q.push_back({full[8*i +: 8], i == N-1, (i == N-1) ? full[32] : 1'b0});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; cin = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_out_sum", {24'd0, out_sum}, 32'd0);
    check("reset_out_last", {30'd0, out_last, out_carry}, 32'd0);

    send_word(32'h000000FF, 32'h00000001, 1'b0, -1, -1, -1, 0);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_last", {31'd0, out_last}, 32'd1);
    send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, -1, -1, -1, 0);
    check("overflow_carry", {31'd0, out_carry}, 32'd1);
    send_word(32'h00000000, 32'h00000000, 1'b0, -1, -1, -1, 0);
    check("clean_word_carry", {31'd0, out_carry}, 32'd0);
    send_word(32'h12345678, 32'h11111111, 1'b0, 2, -1, -1, 0);
    send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, -1, 2, -1, 0);
    send_word(32'h00000001, 32'h00000001, 1'b0, -1, -1, -1, 0);
    send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, -1, -1, 2, 0);
    send_word(32'h01020304, 32'h10203040, 1'b0, -1, -1, -1, 0);
`ifdef SERIAL_ADDER_CIN_EN
    send_word(32'h00000000, 32'h00000000, 1'b1, -1, -1, -1, 0);
    check("cin_last_carry", {31'd0, out_carry}, 32'd0);
`endif

    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send_word($urandom, $urandom, 1'($urandom_range(1, 0)), -1, -1, -1, 2);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    out_ready = 1'b1;

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    end
    @(posedge clk); #1;
    check("drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
